// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8-bit UART transmit path (and the
// future uart_rx8): state encoding, serial line levels and frame geometry.
package uart_pkg;

    // Frame phases; PARITY is only reachable when UART_TX8_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Serial line levels.
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Frame geometry.
    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    // Bit timer width; wide enough for CLKS_PER_BIT up to 255.
    localparam int TIMER_W = 8;

endpackage : uart_pkg

// File: rtl/uart_tx8_if.sv
// uart_tx8_if: valid/ready byte handshake into the UART transmitter.
// The producer uses the master modport, the transmitter the slave modport.
interface uart_tx8_if;

    logic [7:0] tx_in;     // byte to send, sampled only on acceptance
    logic       tx_valid;  // tx_in holds a byte to send
    logic       tx_ready;  // transmitter can accept a byte

    modport master (
        output tx_in,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_in,
        input  tx_valid,
        output tx_ready
    );

endinterface : uart_tx8_if

// File: rtl/bit_timer.sv
// bit_timer: counts CLKS_PER_BIT clock cycles per serial bit and pulses
// bit_end on the last cycle of each bit period. Holds while En is low and
// is forced to zero while clear is high. Shared with the receive side.
module bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4  // legal range 1..255
) (
    input  logic Clk,
    input  logic Res,      // asynchronous, active-low
    input  logic En,
    input  logic clear,
    output logic bit_end
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the end of a bit.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (En) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TIMER_W'(1);
        end
    end

    // The bit period ends on the edge where the count sits at LAST with En high.
    assign bit_end = En & ~clear & (cnt_q == LAST);

    // Count register.
    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule : bit_timer

// File: rtl/uart_tx8.sv
// uart_tx8: 8-bit parallel-in, serial-out frame transmitter.
// Frame is 8N1 by default: start 0, eight data bits LSB first, stop 1.
// Defining UART_TX8_PARITY_EN inserts an even-parity bit before the stop
// bit (8E1, 11 bit periods per frame).
// Bytes arrive over a valid/ready handshake; tx_out and busy are registered.
module uart_tx8
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4  // legal range 1..255
) (
    input  logic       Clk,
    input  logic       Res,      // asynchronous, active-low
    input  logic       En,       // global enable; low freezes everything
    uart_tx8_if.slave  bus,
    output logic       tx_out,   // serial line, idles high
    output logic       busy      // a frame is in progress
);

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic                   tx_out_q;
    logic                   busy_q;
`ifdef UART_TX8_PARITY_EN
    logic                   parity_q;
`endif

    logic accept;
    logic bit_end;
    logic timer_clear;

    // Ready only while idle, enabled and out of reset; reset forces it low
    // without waiting for a clock edge.
    assign bus.tx_ready = (state_q == IDLE) & En & Res;
    assign accept       = bus.tx_valid & bus.tx_ready;

    // The timer sits at zero while idle, so each frame starts a fresh bit period.
    assign timer_clear  = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk     (Clk),
        .Res     (Res),
        .En      (En),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // Frame sequencer: state, shift register, bit index and registered line outputs.
    // Every transition needs accept or bit_end, both of which include En, so
    // En low freezes the frame and stretches the current bit.
    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            // NOTE: the shift register is reset along with control so an aborted
            // frame leaves no stale data behind.
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_out_q  <= IDLE_LVL;
            busy_q    <= 1'b0;
`ifdef UART_TX8_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q   <= bus.tx_in;
                        bit_idx_q <= '0;
                        state_q   <= START;
                        tx_out_q  <= START_LVL;
                        busy_q    <= 1'b1;
`ifdef UART_TX8_PARITY_EN
                        parity_q  <= ^bus.tx_in;
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        state_q  <= DATA;
                        tx_out_q <= shreg_q[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
`ifdef UART_TX8_PARITY_EN
                            state_q   <= PARITY;
                            tx_out_q  <= parity_q;
`else
                            state_q   <= STOP;
                            tx_out_q  <= STOP_LVL;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                            // Next bit is the one that moves into position 0.
                            tx_out_q  <= shreg_q[1];
                        end
                    end
                end

`ifdef UART_TX8_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q  <= STOP;
                        tx_out_q <= STOP_LVL;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        state_q  <= IDLE;
                        tx_out_q <= IDLE_LVL;
                        busy_q   <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to an idle line.
                    state_q  <= IDLE;
                    tx_out_q <= IDLE_LVL;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = tx_out_q;
    assign busy   = busy_q;

endmodule : uart_tx8

// File: tb/tb_uart_tx8.sv
// tb_uart_tx8: self-checking bench for uart_tx8. Two instances share clock,
// reset and enable: dut_a with CLKS_PER_BIT=4 and dut_b with CLKS_PER_BIT=1.
// Expected line waveforms come from a frame model built from the byte.
module tb_uart_tx8;

    localparam int CPB_A = 4;
    localparam int CPB_B = 1;
`ifdef UART_TX8_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic out_a, busy_a, out_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx8_if bus_a ();
    uart_tx8_if bus_b ();

    uart_tx8 #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .Clk    (clk),
        .Res    (rst_n),
        .En     (en),
        .bus    (bus_a.slave),
        .tx_out (out_a),
        .busy   (busy_a)
    );

    uart_tx8 #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .Clk    (clk),
        .Res    (rst_n),
        .En     (en),
        .bus    (bus_b.slave),
        .tx_out (out_b),
        .busy   (busy_b)
    );

    function automatic logic get_out(input int sel);
        return (sel != 0) ? out_b : out_a;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? bus_b.tx_ready : bus_a.tx_ready;
    endfunction

    task automatic drive(input int sel, input logic valid, input logic [7:0] data);
        if (sel != 0) begin
            bus_b.tx_valid = valid;
            bus_b.tx_in    = data;
        end else begin
            bus_a.tx_valid = valid;
            bus_a.tx_in    = data;
        end
    endtask

    // Expected line level per cycle after acceptance: each frame bit held for
    // cpb cycles; an enable gap of l cycles starting at cycle p repeats the
    // level seen in cycle p for l more cycles.
    task automatic model_frame(input logic [7:0] b, input int cpb, input int p, input int l);
        logic bits[$];
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX8_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < cpb; k++) exp_q.push_back(bits[i]);
        end
        for (int k = 0; k < l; k++) exp_q.insert(p + 1, exp_q[p]);
    endtask

    // Sends one byte with a one-cycle valid pulse and checks line, busy and gap.
    task automatic run_frame(input string name, input int sel, input logic [7:0] b,
                             input int p, input int l);
        int   cpb;
        int   total;
        int   busy_cnt;
        int   bad_idx;
        logic got[$];
        cpb = (sel != 0) ? CPB_B : CPB_A;
        model_frame(b, cpb, p, l);
        total = exp_q.size();

        @(negedge clk);
        en = 1'b1;
        drive(sel, 1'b1, b);
        #1;
        n_cmp++;
        if (get_ready(sel) !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, get_ready(sel));
        end

        @(negedge clk);
        drive(sel, 1'b0, 8'($urandom));  // later tx_in changes must be ignored
        busy_cnt = 0;
        got.delete();
        for (int c = 0; c < total; c++) begin
            got.push_back(get_out(sel));
            if (get_busy(sel) === 1'b1) busy_cnt++;
            en = !(l > 0 && c >= p && c < p + l);
            @(negedge clk);
        end
        en = 1'b1;
        #1;

        bad_idx = -1;
        for (int i = 0; i < total; i++) begin
            if (got[i] !== exp_q[i] && bad_idx < 0) bad_idx = i;
        end
        n_cmp++;
        if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL %s tx_out: byte %02h cycle %0d got %b want %b",
                     name, b, bad_idx, got[bad_idx], exp_q[bad_idx]);
        end

        n_cmp++;
        if (busy_cnt !== total) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, total);
        end

        n_cmp++;
        if ({get_busy(sel), get_out(sel), get_ready(sel)} !== 3'b011) begin
            n_bad++;
            $display("FAIL %s idle_gap busy/out/ready: got %b%b%b want 011",
                     name, get_busy(sel), get_out(sel), get_ready(sel));
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        en    = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_a, busy_a, bus_a.tx_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_a out/busy/ready: got %b%b%b want 100", out_a, busy_a, bus_a.tx_ready);
        end
        n_cmp++;
        if ({out_b, busy_b, bus_b.tx_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_b out/busy/ready: got %b%b%b want 100", out_b, busy_b, bus_b.tx_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus_a.tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release ready: got %b want 1", bus_a.tx_ready);
        end

        // Abort a frame of zeros mid-data, away from any clock edge.
        @(negedge clk);
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_a, busy_a, bus_a.tx_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL async_abort out/busy/ready: got %b%b%b want 100", out_a, busy_a, bus_a.tx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a, bus_a.tx_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL abort_release busy/ready: got %b%b want 01", busy_a, bus_a.tx_ready);
        end
        bad = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (out_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL abort_no_resume: got %0d non-idle cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic seq[$];
        int   fl;
        int   total;
        int   bad_out;
        int   bad_rdy;
        int   second_start;
        fl = NBITS * CPB_A;
        model_frame(8'h00, CPB_A, 0, 0);
        seq = exp_q;
        seq.push_back(1'b1);
        model_frame(8'hFF, CPB_A, 0, 0);
        foreach (exp_q[i]) seq.push_back(exp_q[i]);
        total = seq.size();

        @(negedge clk);
        en = 1'b1;
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        bad_out = 0;
        bad_rdy = 0;
        second_start = -1;
        for (int c = 0; c < total; c++) begin
            if (out_a !== seq[c]) bad_out++;
            if (bus_a.tx_ready !== (c == fl)) bad_rdy++;
            if (c >= fl && second_start < 0 && out_a === 1'b0) second_start = c;
            if (c == fl + 1) drive(0, 1'b0, 8'($urandom));
            @(negedge clk);
        end
        n_cmp++;
        if (bad_out != 0) begin
            n_bad++;
            $display("FAIL b2b tx_out: got %0d wrong cycles want 0", bad_out);
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_bad++;
            $display("FAIL b2b tx_ready: got %0d wrong cycles want 0", bad_rdy);
        end
        n_cmp++;
        if (second_start != fl + 1) begin
            n_bad++;
            $display("FAIL b2b start_spacing: got %0d want %0d", second_start, fl + 1);
        end
        n_cmp++;
        if ({busy_a, out_a} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b final_idle busy/out: got %b%b want 01", busy_a, out_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int p;
        int l;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(1, NBITS * CPB_A - 2);
                l = $urandom_range(1, 3);
            end else begin
                p = 0;
                l = 0;
            end
            run_frame("random_a", 0, b, p, l);
        end
        for (int i = 0; i < 4; i++) begin
            run_frame("random_b", 1, 8'($urandom), 0, 0);
        end
    endtask

    initial begin
        bus_a.tx_valid = 1'b0;
        bus_a.tx_in    = 8'h00;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_in    = 8'h00;
        test_reset();
        run_frame("byte_a5", 0, 8'hA5, 0, 0);
        test_back_to_back();
        run_frame("stall_3c", 0, 8'h3C, 13, 3);
        run_frame("cpb1_81", 1, 8'h81, 0, 0);
`ifdef UART_TX8_PARITY_EN
        run_frame("parity_07", 0, 8'h07, 0, 0);
        run_frame("parity_03", 0, 8'h03, 0, 0);
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_tx8
